// File: rtl/ac_stress_seq.sv
// AC stress sequencer: alternates STRESS and RELAX phases timed in 4096-cycle
// divider epochs, repeating the pair a programmed number of times.
module ac_stress_seq #(
    parameter int EPOCH_W = 16,
    parameter int CYC_W   = 8
) (
    input  logic               AC_STRESS_CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               ABORT,
    input  logic [EPOCH_W-1:0] STRESS_EPOCHS,
    input  logic [EPOCH_W-1:0] RELAX_EPOCHS,
    input  logic [CYC_W-1:0]   NUM_CYCLES,
    input  logic               FREQ_DIV_OUT,
    output logic               DIV_RESETB,
    output logic               STRESS_EN,
    output logic               RELAX_EN,
    output logic               BUSY,
    output logic               DONE,
    output logic [EPOCH_W-1:0] EPOCH_CNT,
    output logic [CYC_W-1:0]   CYCLE_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        S_ARM,
        STRESS,
        R_ARM,
        RELAX,
        FIN
    } state_t;

    state_t             state_reg, state_next;
    logic               prev_div_reg;
    logic [EPOCH_W-1:0] stress_epochs_reg, stress_epochs_next;
    logic [EPOCH_W-1:0] relax_epochs_reg, relax_epochs_next;
    logic [CYC_W-1:0]   num_cycles_reg, num_cycles_next;
    logic [EPOCH_W-1:0] epoch_cnt_reg, epoch_cnt_next;
    logic [CYC_W-1:0]   cycle_cnt_reg, cycle_cnt_next;

    logic               div_resetb_reg, div_resetb_next;
    logic               stress_en_reg, stress_en_next;
    logic               relax_en_reg, relax_en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               tick;
    logic [EPOCH_W-1:0] epoch_inc;
    logic [CYC_W-1:0]   cycle_inc;

    // Falling MSB marks the divider wrapping 4095 -> 0, i.e. one completed epoch.
    assign tick      = prev_div_reg & ~FREQ_DIV_OUT;
    assign epoch_inc = epoch_cnt_reg + EPOCH_W'(1);
    assign cycle_inc = cycle_cnt_reg + CYC_W'(1);

    always_comb begin
        state_next         = state_reg;
        stress_epochs_next = stress_epochs_reg;
        relax_epochs_next  = relax_epochs_reg;
        num_cycles_next    = num_cycles_reg;
        epoch_cnt_next     = epoch_cnt_reg;
        cycle_cnt_next     = cycle_cnt_reg;

        if (state_reg != IDLE && ABORT) begin
            // Abort freezes both counters; only the state returns to IDLE.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (START && !ABORT) begin
                        stress_epochs_next = STRESS_EPOCHS;
                        relax_epochs_next  = RELAX_EPOCHS;
                        num_cycles_next    = NUM_CYCLES;
                        cycle_cnt_next     = '0;
                        if (STRESS_EPOCHS == '0 || NUM_CYCLES == '0) begin
                            state_next = FIN;
                        end else begin
                            state_next = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    epoch_cnt_next = '0;
                    state_next     = STRESS;
                end
                STRESS: begin
                    if (tick) begin
                        epoch_cnt_next = epoch_inc;
                        if (epoch_inc == stress_epochs_reg) begin
                            if (relax_epochs_reg != '0) begin
                                state_next = R_ARM;
                            end else begin
                                cycle_cnt_next = cycle_inc;
                                state_next     = (cycle_inc == num_cycles_reg) ? FIN : S_ARM;
                            end
                        end
                    end
                end
                R_ARM: begin
                    epoch_cnt_next = '0;
                    state_next     = RELAX;
                end
                RELAX: begin
                    if (tick) begin
                        epoch_cnt_next = epoch_inc;
                        if (epoch_inc == relax_epochs_reg) begin
                            cycle_cnt_next = cycle_inc;
                            state_next     = (cycle_inc == num_cycles_reg) ? FIN : S_ARM;
                        end
                    end
                end
                FIN: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so DIV_RESETB is glitch-free.
    always_comb begin
        div_resetb_next = (state_next == STRESS) || (state_next == RELAX);
        stress_en_next  = (state_next == S_ARM) || (state_next == STRESS);
        relax_en_next   = (state_next == R_ARM) || (state_next == RELAX);
        busy_next       = (state_next != IDLE);
        done_next       = (state_next == FIN);
    end

    always_ff @(posedge AC_STRESS_CLK or posedge RESET) begin
        if (RESET) begin
            state_reg         <= IDLE;
            prev_div_reg      <= 1'b0;
            stress_epochs_reg <= '0;
            relax_epochs_reg  <= '0;
            num_cycles_reg    <= '0;
            epoch_cnt_reg     <= '0;
            cycle_cnt_reg     <= '0;
            div_resetb_reg    <= 1'b0;
            stress_en_reg     <= 1'b0;
            relax_en_reg      <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            prev_div_reg      <= FREQ_DIV_OUT;
            stress_epochs_reg <= stress_epochs_next;
            relax_epochs_reg  <= relax_epochs_next;
            num_cycles_reg    <= num_cycles_next;
            epoch_cnt_reg     <= epoch_cnt_next;
            cycle_cnt_reg     <= cycle_cnt_next;
            div_resetb_reg    <= div_resetb_next;
            stress_en_reg     <= stress_en_next;
            relax_en_reg      <= relax_en_next;
            busy_reg          <= busy_next;
            done_reg          <= done_next;
        end
    end

    assign DIV_RESETB = div_resetb_reg;
    assign STRESS_EN  = stress_en_reg;
    assign RELAX_EN   = relax_en_reg;
    assign BUSY       = busy_reg;
    assign DONE       = done_reg;
    assign EPOCH_CNT  = epoch_cnt_reg;
    assign CYCLE_CNT  = cycle_cnt_reg;

endmodule
